// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg
//   Shared types and constants for the I2C slave receive path.
//   - rx_ctrl_state_t : states of the receive sequencer
//   - GC_ADDR         : 7-bit general-call address
//   - addr_hit()      : address-phase match (own address or enabled general call)
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR_RX   = 4'd1,
    ADDR_CHK  = 4'd2,
    DATA_RX   = 4'd3,
    DATA_CHK  = 4'd4,
    ACK_SETUP = 4'd5,
    ACK_DRIVE = 4'd6,
    TX_HAND   = 4'd7,
    IGNORE    = 4'd8
  } rx_ctrl_state_t;

  localparam logic [6:0] GC_ADDR = 7'h00;

  // General call is a write-only address, so the full byte (R/W = 0) must match.
  function automatic logic addr_hit(input logic [7:0] rx_byte,
                                    input logic [6:0] own_addr,
                                    input logic       gc_en);
    return (rx_byte[7:1] == own_addr) || (gc_en && (rx_byte == {GC_ADDR, 1'b0}));
  endfunction

endpackage

// File: rtl/i2c_slave_rx_ctrl_flex_counter.sv
// flex_counter
//   Bit counter for the receive sequencer. Counts on count_enable, wraps back
//   to 1 after reaching rollover_val, synchronous clear has priority.
//   Ports:
//     clk, n_rst    : clock, asynchronous active-low reset
//     clear         : synchronous clear to 0
//     count_enable  : increment request
//     rollover_val  : terminal count
//     count_out     : current count
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_r;

  // Count register: clear first, then increment with wrap at rollover_val.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_enable) begin
      if (count_r >= rollover_val) begin
        count_r <= NUM_CNT_BITS'(1);
      end else begin
        count_r <= count_r + NUM_CNT_BITS'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count_out = count_r;

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// i2c_slave_rx_ctrl
//   Sequencer for the I2C slave receive path: gates the RX shift register,
//   counts bits, checks the address, drives ACK/NACK in the 9th clock, pushes
//   received bytes to the RX FIFO and hands read transfers to the TX path.
//   Ports:
//     clk, n_rst                 : clock, asynchronous active-low reset
//     start_found, stop_found    : 1-cycle START / STOP pulses
//     rising_edge, falling_edge  : 1-cycle synchronised SCL edge pulses
//     rx_data[7:0]               : RX shift register contents (MSB first)
//     slave_addr[6:0]            : configured slave address
//     fifo_full                  : RX FIFO full
//     rx_enable                  : shift register enable (ANDed with rising_edge there)
//     sda_drive_low              : 1 = pull SDA low (ACK)
//     fifo_wr, fifo_wdata[7:0]   : RX FIFO write strobe and data
//     addr_match                 : 1-cycle pulse on accepted address
//     rw_mode                    : R/W bit of the accepted address, held until IDLE
//     tx_active                  : read transfer owned by the TX path
//     rx_overflow                : 1-cycle pulse, byte dropped on full FIFO
//     busy                       : state != IDLE
module i2c_slave_rx_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int GC_EN     = 0,
  parameter int BYTE_BITS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge,
  input  logic       falling_edge,
  input  logic [7:0] rx_data,
  input  logic [6:0] slave_addr,
  input  logic       fifo_full,
  output logic       rx_enable,
  output logic       sda_drive_low,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       addr_match,
  output logic       rw_mode,
  output logic       tx_active,
  output logic       rx_overflow,
  output logic       busy
);

  localparam logic [3:0] ROLLOVER_VAL = 4'(BYTE_BITS);
  localparam logic [3:0] LAST_BIT     = 4'(BYTE_BITS - 1);

  rx_ctrl_state_t state_r;
  rx_ctrl_state_t fsm_nxt_s;
  rx_ctrl_state_t state_nxt_s;
  logic [3:0]     bit_cnt_s;
  logic           cnt_clear_s;
  logic           cnt_en_s;
  logic           byte_done_s;
  logic           ack_val_r;
  logic           rw_mode_r;

  // Bit counter; restarted on every START and at the start of each data byte.
  assign cnt_en_s    = rising_edge & rx_enable;
  assign cnt_clear_s = start_found | ((state_r == ACK_DRIVE) && (state_nxt_s == DATA_RX));
  // The edge that completes the byte is the one seen while the count is at BYTE_BITS-1.
  assign byte_done_s = cnt_en_s && (bit_cnt_s == LAST_BIT);

  flex_counter #(
    .NUM_CNT_BITS (4)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear_s),
    .count_enable (cnt_en_s),
    .rollover_val (ROLLOVER_VAL),
    .count_out    (bit_cnt_s)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // ACK value is decided in the check states and consumed in ACK_DRIVE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ack_val_r <= 1'b0;
    end else if (state_r == ADDR_CHK) begin
      ack_val_r <= 1'b1;
    end else if (state_r == DATA_CHK) begin
      ack_val_r <= ~fifo_full;
    end else begin
      ack_val_r <= ack_val_r;
    end
  end

  // R/W bit of the accepted address; cleared when the bus returns to IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rw_mode_r <= 1'b0;
    end else if (stop_found) begin
      rw_mode_r <= 1'b0;
    end else if (addr_match) begin
      rw_mode_r <= rx_data[0];
    end else begin
      rw_mode_r <= rw_mode_r;
    end
  end

  assign rw_mode = rw_mode_r;

  // Next-state and Moore/Mealy outputs; STOP, then START, override the per-state decision.
  always_comb begin
    fsm_nxt_s     = state_r;
    rx_enable     = 1'b0;
    sda_drive_low = 1'b0;
    fifo_wr       = 1'b0;
    fifo_wdata    = 8'h00;
    addr_match    = 1'b0;
    tx_active     = 1'b0;
    rx_overflow   = 1'b0;
    busy          = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        fsm_nxt_s = IDLE;
      end
      ADDR_RX: begin
        rx_enable = 1'b1;
        if (byte_done_s) begin
          fsm_nxt_s = ADDR_CHK;
        end else begin
          fsm_nxt_s = ADDR_RX;
        end
      end
      ADDR_CHK: begin
        if (addr_hit(rx_data, slave_addr, (GC_EN != 0))) begin
          addr_match = 1'b1;
          fsm_nxt_s  = ACK_SETUP;
        end else begin
          fsm_nxt_s  = IGNORE;
        end
      end
      DATA_RX: begin
        rx_enable = 1'b1;
        if (byte_done_s) begin
          fsm_nxt_s = DATA_CHK;
        end else begin
          fsm_nxt_s = DATA_RX;
        end
      end
      DATA_CHK: begin
        if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = rx_data;
        end else begin
          rx_overflow = 1'b1;
        end
        fsm_nxt_s = ACK_SETUP;
      end
      ACK_SETUP: begin
        // SDA may only change while SCL is low.
        if (falling_edge) begin
          fsm_nxt_s = ACK_DRIVE;
        end else begin
          fsm_nxt_s = ACK_SETUP;
        end
      end
      ACK_DRIVE: begin
        sda_drive_low = ack_val_r;
        if (falling_edge) begin
          if (!ack_val_r) begin
            fsm_nxt_s = IGNORE;
          end else if (rw_mode_r) begin
            // rw_mode can only be 1 after an address phase; reads never reach DATA_RX.
            fsm_nxt_s = TX_HAND;
          end else begin
            fsm_nxt_s = DATA_RX;
          end
        end else begin
          fsm_nxt_s = ACK_DRIVE;
        end
      end
      TX_HAND: begin
        tx_active = 1'b1;
        fsm_nxt_s = TX_HAND;
      end
      IGNORE: begin
        fsm_nxt_s = IGNORE;
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
    state_nxt_s = stop_found  ? IDLE    :
                  start_found ? ADDR_RX : fsm_nxt_s;
  end

endmodule
